// File: rtl/jacobi_sweep_sched_pkg.sv
// Shared constants, state encoding and address helper for the Jacobi sweep sequencer.
package jacobi_sweep_sched_pkg;

  localparam int JACOBI_N          = 8;
  localparam int JACOBI_ADDR_WIDTH = 8;
  localparam int JACOBI_MEM_SIZE   = 256;
  localparam int JACOBI_N_PAIRS    = JACOBI_N * (JACOBI_N - 1) / 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } jacobi_sched_state_t;

  // Row-major word offset of element (r,c) within the matrix.
  function automatic logic [31:0] jacobi_addr(input logic [31:0] r, input logic [31:0] c);
    return r * JACOBI_N + c;
  endfunction

endpackage

// File: rtl/jacobi_pair_gen.sv
// Row-cyclic (p,q) iterator over the strict upper triangle, p<q, with a pair index.
module jacobi_pair_gen
  import jacobi_sweep_sched_pkg::*;
#(
  parameter int N  = JACOBI_N,
  parameter int PW = $clog2(N),
  parameter int IW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          advance,
  output logic [PW-1:0] p_o,
  output logic [PW-1:0] q_o,
  output logic [IW-1:0] idx_o,
  output logic          last_o
);

  always_ff @(posedge clk) begin
    if (rst) begin
      p_o   <= '0;
      q_o   <= '0;
      idx_o <= '0;
    end else if (clear) begin
      p_o   <= '0;
      q_o   <= PW'(1);
      idx_o <= '0;
    end else if (advance) begin
      if (q_o < PW'(N - 1)) begin
        q_o <= q_o + PW'(1);
      end else begin
        p_o <= p_o + PW'(1);
        q_o <= p_o + PW'(2);
      end
      idx_o <= idx_o + IW'(1);
    end
  end

  assign last_o = (p_o == PW'(N - 2)) && (q_o == PW'(N - 1));

endmodule

// File: rtl/jacobi_sweep_sched.sv
// Jacobi sweep sequencer: issues one rotation per (p,q) pair, repeats sweeps until
// convergence or the sweep limit.
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_ISSUE  | rotation request valid, waiting for rot_ready_i
//   S_WAIT   | request accepted, waiting for rot_done_i
//   S_FINISH | one-cycle done pulse
module jacobi_sweep_sched
  import jacobi_sweep_sched_pkg::*;
#(
  parameter  int N        = JACOBI_N,
  parameter  int ADDR_W   = JACOBI_ADDR_WIDTH,
  parameter  int MAT_BASE = 0,
  parameter  int SWEEP_W  = 8,
  localparam int PW       = $clog2(N),
  localparam int NPAIRS   = N * (N - 1) / 2,
  localparam int IW       = (NPAIRS > 1) ? $clog2(NPAIRS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [SWEEP_W-1:0] n_sweeps_i,
  input  logic               conv_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               conv_o,
  output logic               rot_valid_o,
  input  logic               rot_ready_i,
  output logic [PW-1:0]      rot_p_o,
  output logic [PW-1:0]      rot_q_o,
  output logic [ADDR_W-1:0]  addr_pp_o,
  output logic [ADDR_W-1:0]  addr_qq_o,
  output logic [ADDR_W-1:0]  addr_pq_o,
  input  logic               rot_done_i,
  output logic [IW-1:0]      pair_idx_o,
  output logic [SWEEP_W-1:0] sweep_cnt_o
);

  // jacobi_addr() is tied to the package dimension; refuse mismatched or overflowing builds.
  if (N != JACOBI_N || N < 2 || MAT_BASE + N * N > JACOBI_MEM_SIZE ||
      MAT_BASE + N * N > (1 << ADDR_W)) begin : g_param_check
    $error("jacobi_sweep_sched: bad dimension or matrix exceeds address space");
  end

  jacobi_sched_state_t state, state_nxt;
  logic [SWEEP_W-1:0]  sweeps_left;
  logic [SWEEP_W-1:0]  sweep_cnt;
  logic                conv_q;
  logic                pg_clear, pg_adv, pg_last, sweep_end;

  jacobi_pair_gen #(.N(N), .PW(PW), .IW(IW)) u_pair_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (pg_clear),
    .advance (pg_adv),
    .p_o     (rot_p_o),
    .q_o     (rot_q_o),
    .idx_o   (pair_idx_o),
    .last_o  (pg_last)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pg_clear  = 1'b0;
    pg_adv    = 1'b0;
    sweep_end = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          pg_clear  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (rot_ready_i) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (rot_done_i) begin
          if (!pg_last) begin
            pg_adv    = 1'b1;
            state_nxt = S_ISSUE;
          end else begin
            sweep_end = 1'b1;
            if (conv_i || sweeps_left == SWEEP_W'(1)) begin
              state_nxt = S_FINISH;
            end else begin
              pg_clear  = 1'b1;
              state_nxt = S_ISSUE;
            end
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Remaining-sweep down-counter terminates at 1; conv_i is zero unless this sweep ends the solve.
  always_ff @(posedge clk) begin
    if (rst) begin
      sweeps_left <= '0;
      sweep_cnt   <= '0;
      conv_q      <= 1'b0;
    end else if (state == S_IDLE && start_i) begin
      sweeps_left <= (n_sweeps_i == '0) ? SWEEP_W'(1) : n_sweeps_i;
      sweep_cnt   <= '0;
      conv_q      <= 1'b0;
    end else if (sweep_end) begin
      sweeps_left <= sweeps_left - SWEEP_W'(1);
      sweep_cnt   <= sweep_cnt + SWEEP_W'(1);
      conv_q      <= conv_i;
    end
  end

  assign busy_o      = (state != S_IDLE);
  assign done_o      = (state == S_FINISH);
  assign rot_valid_o = (state == S_ISSUE);
  assign conv_o      = conv_q;
  assign sweep_cnt_o = sweep_cnt;

  assign addr_pp_o = ADDR_W'(MAT_BASE + jacobi_addr(32'(rot_p_o), 32'(rot_p_o)));
  assign addr_qq_o = ADDR_W'(MAT_BASE + jacobi_addr(32'(rot_q_o), 32'(rot_q_o)));
  assign addr_pq_o = ADDR_W'(MAT_BASE + jacobi_addr(32'(rot_p_o), 32'(rot_q_o)));

endmodule
